shared_vc_claim_tracker: RTL

- Input-port-side counterpart of the per-bank shared-buffer ownership allocator.
- Consumes each bank's ownership grant and ready_for_allocation, and claims shared VCs for new packets arriving at this port.
- Releases claimed VCs on tail departure.
- Drives this port's allocated-shared-IVC vector back to every bank allocator, which uses it to detect bank idleness before rotating ownership.

---
 rtl/shared_vc_claim_tracker_if.sv | 29 ++
 rtl/shared_vc_claim_tracker.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/shared_vc_claim_tracker_if.sv
// rtl/shared_vc_claim_tracker_if.sv - alloc/release handshake between input port logic and the shared VC claim tracker
interface shared_vc_claim_tracker_if #(
    parameter int vc_idx_width = 4
);
    logic                    alloc_req;
    logic                    alloc_ack;
    logic                    alloc_nack;
    logic [vc_idx_width-1:0] alloc_vc;
    logic                    release_valid;
    logic [vc_idx_width-1:0] release_vc;

    modport master (
        output alloc_req,
        output release_valid,
        output release_vc,
        input  alloc_ack,
        input  alloc_nack,
        input  alloc_vc
    );

    modport slave (
        input  alloc_req,
        input  release_valid,
        input  release_vc,
        output alloc_ack,
        output alloc_nack,
        output alloc_vc
    );
endinterface

// File: rtl/shared_vc_claim_tracker.sv
// rtl/shared_vc_claim_tracker.sv - claims shared VCs in banks owned by this input port and releases them on tail departure
module shared_vc_claim_tracker #(
    parameter int num_ports        = 5,
    parameter int num_vcs_per_bank = 2,
    parameter int port_id          = 0,
    parameter int num_vcs          = num_ports * num_vcs_per_bank,
    parameter int vc_idx_width     = $clog2(num_vcs)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [num_ports-1:0]     bank_grant,
    input  logic [num_ports-1:0]     bank_ready,
    shared_vc_claim_tracker_if.slave alloc_bus,
    output logic [num_vcs-1:0]       allocated_shared_ivc,
    output logic [vc_idx_width:0]    free_count,
    output logic                     protocol_error
);

    localparam int bank_w = (num_ports > 1) ? $clog2(num_ports) : 1;

    if (port_id < 0 || port_id >= num_ports) begin : g_bad_port_id
        $error("port_id out of range");
    end

    logic [num_ports-1:0]    bank_elig;
    logic [num_ports-1:0]    bank_has_free;
    logic [num_vcs-1:0]      vc_bank_elig;
    logic [num_vcs-1:0]      vc_free;
    logic [num_vcs-1:0]      vc_revoke;
    logic [num_vcs-1:0]      rel_dec;
    logic [num_vcs-1:0]      ack_dec;
    logic [num_vcs-1:0]      claims_next;
    logic [bank_w-1:0]       rr_ptr;
    logic [bank_w-1:0]       rr_next;
    logic [bank_w-1:0]       pick_bank;
    logic                    pick_found;
    logic                    slot_found;
    logic [vc_idx_width-1:0] pick_vc;
    logic                    grant_now;
    logic                    rel_err;
    logic [vc_idx_width:0]   free_next;
    int                      cand;
    int                      vi;

    assign bank_elig = bank_grant & bank_ready;

    // Per-VC views of bank state; eligibility always uses the pre-update claims,
    // so a VC released this cycle cannot be re-claimed until the next one.
    always_comb begin
        vc_bank_elig = '0;
        vc_revoke    = '0;
        rel_dec      = '0;
        for (int v = 0; v < num_vcs; v++) begin
            vc_bank_elig[v] = bank_elig[v / num_vcs_per_bank];
            vc_revoke[v]    = allocated_shared_ivc[v] & ~bank_grant[v / num_vcs_per_bank];
            rel_dec[v]      = alloc_bus.release_valid &&
                              (alloc_bus.release_vc == vc_idx_width'(v));
        end
    end

    assign vc_free = vc_bank_elig & ~allocated_shared_ivc;

    always_comb begin
        bank_has_free = '0;
        for (int b = 0; b < num_ports; b++) begin
            bank_has_free[b] = |vc_free[b*num_vcs_per_bank +: num_vcs_per_bank];
        end
    end

    // Round-robin bank pick starting at rr_ptr, then lowest free slot in that bank.
    always_comb begin
        cand       = 0;
        pick_found = 1'b0;
        pick_bank  = '0;
        for (int i = 0; i < num_ports; i++) begin
            cand = (int'(rr_ptr) + i) % num_ports;
            if (!pick_found && bank_has_free[cand]) begin
                pick_found = 1'b1;
                pick_bank  = bank_w'(cand);
            end
        end
    end

    always_comb begin
        vi         = 0;
        slot_found = 1'b0;
        pick_vc    = '0;
        for (int s = 0; s < num_vcs_per_bank; s++) begin
            vi = int'(pick_bank) * num_vcs_per_bank + s;
            if (!slot_found && vc_free[vi]) begin
                slot_found = 1'b1;
                pick_vc    = vc_idx_width'(vi);
            end
        end
    end

    assign grant_now = alloc_bus.alloc_req && pick_found;

    always_comb begin
        ack_dec = '0;
        for (int v = 0; v < num_vcs; v++) begin
            ack_dec[v] = grant_now && (pick_vc == vc_idx_width'(v));
        end
    end

    // Out-of-range release_vc decodes to no bit at all, so it also lands here.
    assign rel_err     = alloc_bus.release_valid && !(|(rel_dec & allocated_shared_ivc));
    assign claims_next = (allocated_shared_ivc & ~(rel_dec & allocated_shared_ivc) & ~vc_revoke)
                         | ack_dec;
    assign rr_next     = (int'(pick_bank) == num_ports - 1) ? '0 : pick_bank + 1'b1;

    always_comb begin
        free_next = '0;
        for (int v = 0; v < num_vcs; v++) begin
            free_next = free_next + {{vc_idx_width{1'b0}}, vc_bank_elig[v] & ~claims_next[v]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            allocated_shared_ivc <= '0;
            alloc_bus.alloc_ack  <= 1'b0;
            alloc_bus.alloc_nack <= 1'b0;
            alloc_bus.alloc_vc   <= '0;
            free_count           <= '0;
            protocol_error       <= 1'b0;
            rr_ptr               <= '0;
        end else begin
            allocated_shared_ivc <= claims_next;
            alloc_bus.alloc_ack  <= grant_now;
            alloc_bus.alloc_nack <= alloc_bus.alloc_req && !pick_found;
            free_count           <= free_next;
            protocol_error       <= protocol_error | rel_err | (|vc_revoke);
            if (grant_now) begin
                alloc_bus.alloc_vc <= pick_vc;
                rr_ptr             <= rr_next;
            end
        end
    end

endmodule
